// File: rtl/fetch_unit.sv
// Instruction fetch stage. It holds the PC, issues one word read at a time to
// instruction memory, and hands each fetched word to the decoder together with its PC.
`timescale 1ns/1ps
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [DATA_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   state_t                state_q,    state_d;
   logic [DATA_WIDTH-1:0] pc_q,       pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q,   req_pc_d;
   logic [DATA_WIDTH-1:0] instr_q,    instr_d;
   logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                  kill_q,     kill_d;
   logic [DATA_WIDTH-1:0] redirect_tgt;

   assign redirect_tgt = redirect_pc & ALIGN_MASK;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      pc_d       = redirect_valid ? redirect_tgt : pc_q;
      req_pc_d   = req_pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      kill_d     = kill_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            // A redirect coinciding with acceptance lets the old address go out
            // and marks its response for discard.
            if (imem_req_ready) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
               kill_d   = redirect_valid;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d    = imem_resp_data;
                  instr_pc_d = req_pc_q;
                  pc_d       = req_pc_q + PC_STEP;
                  state_d    = S_HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            // Redirect wins over instr_ready; the held word counts as unconsumed.
            if (redirect_valid || instr_ready) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         kill_q     <= kill_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign instr_valid    = (state_q == S_HOLD);
   assign instruction    = instr_q;
   assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// traffic against a transaction-level model and a memory whose contents are a function of the address.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          imem_req_valid;
   logic          imem_req_ready = 1'b0;
   logic [DW-1:0] imem_req_addr;
   logic          imem_resp_valid = 1'b0;
   logic [DW-1:0] imem_resp_data = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [DW-1:0] instruction;
   logic [DW-1:0] instr_pc;
   logic          redirect_valid = 1'b0;
   logic [DW-1:0] redirect_pc = '0;

   always #5 clk = ~clk;

   fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instruction     (instruction),
      .instr_pc        (instr_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   int total = 0;
   int bad   = 0;

   // Model: what the fetch stage owes the outside world.
   bit          m_idle, m_req, m_out, m_kill, m_hold;
   logic [31:0] m_pc, m_out_addr, m_instr, m_ipc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   task automatic model_reset();
      m_idle = 1; m_req = 0; m_out = 0; m_kill = 0; m_hold = 0;
      m_pc = 32'h0; m_out_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
   endtask

   task automatic compare();
      check("req_valid", imem_req_valid, m_req);
      if (m_req) check("req_addr", imem_req_addr, m_pc);
      check("instr_valid", instr_valid, m_hold);
      if (m_hold) begin
         check("instruction", instruction, m_instr);
         check("instr_pc", instr_pc, m_ipc);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic tick(input bit rdy, input bit rv, input logic [31:0] rdata,
                       input bit rdv, input logic [31:0] rpc, input bit ir);
      logic [31:0] tgt;
      imem_req_ready  = rdy;
      imem_resp_valid = rv;
      imem_resp_data  = rdata;
      redirect_valid  = rdv;
      redirect_pc     = rpc;
      instr_ready     = ir;
      tgt = rpc & ~32'h3;
      if (m_idle) begin
         m_idle = 0; m_req = 1;
         if (rdv) m_pc = tgt;
      end else if (m_req) begin
         if (rdy) begin
            m_req = 0; m_out = 1; m_out_addr = m_pc; m_kill = rdv;
         end
         if (rdv) m_pc = tgt;
      end else if (m_out) begin
         if (rv) begin
            m_out = 0;
            if (m_kill || rdv) begin
               m_req = 1; m_kill = 0;
            end else begin
               m_hold = 1; m_instr = rdata; m_ipc = m_out_addr; m_pc = m_out_addr + 32'd4;
            end
         end else if (rdv) begin
            m_kill = 1;
         end
         if (rdv) m_pc = tgt;
      end else if (m_hold) begin
         if (rdv) begin
            m_hold = 0; m_req = 1; m_pc = tgt;
         end else if (ir) begin
            m_hold = 0; m_req = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   bit          mem_busy = 0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt  = 0;
   int          hs_count = 0;

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      rst_n = 1'b1;
      compare();

      // First fetch, 1-cycle memory latency.
      tick(0, 0, 0, 0, 0, 0);
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, 32'h0);
      tick(1, 0, 0, 0, 0, 0);
      check("wait_req_valid", imem_req_valid, 0);
      tick(0, 1, 32'h00AA_A503, 0, 0, 0);
      check("first_instr_valid", instr_valid, 1);
      check("first_instruction", instruction, 32'h00AA_A503);
      check("first_instr_pc", instr_pc, 32'h0);

      // Back-pressure from decode.
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 0, 0, 0, 0);
         check("bp_instruction", instruction, 32'h00AA_A503);
         check("bp_instr_pc", instr_pc, 32'h0);
         check("bp_req_valid", imem_req_valid, 0);
      end
      tick(0, 0, 0, 0, 0, 1);
      check("second_req_addr", imem_req_addr, 32'h4);

      // Redirect while waiting for a response.
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 32'h100, 0);
      tick(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      check("kill_instr_valid", instr_valid, 0);
      check("kill_req_addr", imem_req_addr, 32'h100);
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 32'h1234_5678, 0, 0, 0);
      check("tgt_instruction", instruction, 32'h1234_5678);
      check("tgt_instr_pc", instr_pc, 32'h100);

      // Redirect beats instr_ready in the hold state.
      tick(0, 0, 0, 1, 32'h203, 1);
      check("hold_rd_valid", instr_valid, 0);
      check("hold_rd_addr", imem_req_addr, 32'h200);

      // Redirect coincident with acceptance.
      tick(0, 0, 0, 1, 32'h8, 0);
      check("old_addr", imem_req_addr, 32'h8);
      tick(1, 0, 0, 1, 32'h40, 0);
      check("coinc_req_valid", imem_req_valid, 0);
      tick(0, 1, mem_word(32'h8), 0, 0, 0);
      check("coinc_instr_valid", instr_valid, 0);
      check("coinc_req_addr", imem_req_addr, 32'h40);

      // PC wrap.
      tick(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 32'hCAFE_0001, 0, 0, 0);
      check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      tick(0, 0, 0, 0, 0, 1);
      check("wrap_req_addr", imem_req_addr, 32'h0);

      // Asynchronous reset while a redirected fetch is in flight.
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 32'h300, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req_valid", imem_req_valid, 0);
      check("arst_req_addr", imem_req_addr, 32'h0);
      check("arst_instr_valid", instr_valid, 0);
      check("arst_instruction", instruction, 32'h0);
      check("arst_instr_pc", instr_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      compare();
      // Stale response for the pre-reset request lands in the idle cycle.
      tick(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      check("stale_req_addr", imem_req_addr, 32'h0);
      check("stale_instr_valid", instr_valid, 0);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         bit          rdy, rv, rdv, ir;
         logic [31:0] rd, rpc;
         rdy = ($urandom_range(0, 2) != 0);
         ir  = ($urandom_range(0, 3) != 0);
         rdv = ($urandom_range(0, 11) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : ($urandom & 32'h0000_0FFF);
         rv  = 0;
         rd  = $urandom;
         if (mem_busy) begin
            if (mem_cnt == 0) begin
               rv = 1; rd = mem_word(mem_addr); mem_busy = 0;
            end else begin
               mem_cnt--;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            rv = 1;
         end
         if (instr_valid && ir && !rdv) begin
            check("hs_word", instruction, mem_word(instr_pc));
            hs_count++;
         end
         if (imem_req_valid && rdy) begin
            mem_busy = 1; mem_addr = imem_req_addr; mem_cnt = $urandom_range(0, 3);
         end
         tick(rdy, rv, rd, rdv, rpc, ir);
      end
      check("handshakes_seen", 32'(hs_count > 100), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
